// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result binary-to-BCD converter.
// Holds the FSM state type, default widths and the BCD digit width.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int IN_W_DEF  = 8;
  localparam int NDIG_DEF  = 3;
  localparam int BCD_DIG_W = 4;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 so that
// the following left shift carries correctly into the next decade.
module bcd_digit_adj
  import alu_pkg::*;
(
  input  logic [BCD_DIG_W-1:0] digit_in,
  output logic [BCD_DIG_W-1:0] digit_out
);

  always_comb begin
    digit_out = digit_in;
    if (digit_in >= BCD_DIG_W'(5)) begin
      digit_out = digit_in + BCD_DIG_W'(3);
    end
  end

endmodule

// File: rtl/alu_bcd_converter.sv
// Sequential double-dabble converter from an unsigned ALU result to packed
// BCD, one shift per cycle, with valid/ready handshakes on both sides.
module alu_bcd_converter
  import alu_pkg::*;
#(
  parameter int IN_W = IN_W_DEF,
  parameter int NDIG = NDIG_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IN_W-1:0]           in_value,
  input  logic                      in_neg,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BCD_DIG_W*NDIG-1:0] out_bcd,
  output logic                      out_neg,
  output logic                      busy
);

  localparam int BCD_W = BCD_DIG_W * NDIG;
  localparam int TOT_W = BCD_W + IN_W;
  localparam int CNT_W = $clog2(IN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_W - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IN_W-1:0]  shift_q, shift_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic             sign_q, sign_d;
  logic [BCD_W-1:0] out_bcd_q, out_bcd_d;
  logic             out_neg_q, out_neg_d;

  logic [BCD_W-1:0] bcd_adj;
  logic [TOT_W-1:0] shifted;

  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_digit
      bcd_digit_adj u_adj (
        .digit_in  (bcd_q[gi*BCD_DIG_W +: BCD_DIG_W]),
        .digit_out (bcd_adj[gi*BCD_DIG_W +: BCD_DIG_W])
      );
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    bcd_d     = bcd_q;
    sign_d    = sign_q;
    out_bcd_d = out_bcd_q;
    out_neg_d = out_neg_q;
    shifted   = {bcd_adj, shift_q} << 1;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d = in_value;
          sign_d  = in_neg;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d   = shifted[TOT_W-1:IN_W];
        shift_d = shifted[IN_W-1:0];
        cnt_d   = cnt_q + 1'b1;
        // The edge performing the final shift also publishes the result.
        if (cnt_q == LAST_CNT) begin
          state_d   = DONE;
          out_bcd_d = shifted[TOT_W-1:IN_W];
          out_neg_d = sign_q;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      bcd_q     <= '0;
      sign_q    <= 1'b0;
      out_bcd_q <= '0;
      out_neg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      bcd_q     <= bcd_d;
      sign_q    <= sign_d;
      out_bcd_q <= out_bcd_d;
      out_neg_q <= out_neg_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == SHIFT);
  assign out_bcd   = out_bcd_q;
  assign out_neg   = out_neg_q;

endmodule

// File: tb/tb_alu_bcd_converter.sv
// Self-checking bench for alu_bcd_converter: vector table, handshake and
// reset corner cases, then randomized streaming against a decimal model.
module tb_alu_bcd_converter;

  localparam int IN_W  = 8;
  localparam int NDIG  = 3;
  localparam int BCD_W = 4 * NDIG;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_value = '0;
  logic             in_neg = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [BCD_W-1:0] out_bcd;
  logic             out_neg;
  logic             busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_bcd_converter #(.IN_W(IN_W), .NDIG(NDIG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .in_neg    (in_neg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .out_neg   (out_neg),
    .busy      (busy)
  );

  typedef struct {
    int          value;
    logic        neg;
    logic [11:0] exp_bcd;
    logic        exp_neg;
  } vec_t;

  // Decimal reference: peel digits off with /10 and %10.
  function automatic logic [BCD_W-1:0] ref_bcd(input int v);
    logic [BCD_W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int d = 0; d < NDIG; d++) begin
      r[d*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, required);
    end else begin
      $display("ok   %s: %0h", name, actual);
    end
  endtask

  // Accept one value and wait for its result; returns cycles from accept.
  task automatic accept_and_wait(input int value, input logic neg, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 30) begin
      @(posedge clk); #1; guard++;
    end
    in_value = IN_W'(value);
    in_neg   = neg;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      if (out_valid) break;
      @(posedge clk); #1;
      lat = k;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  vec_t vecs[10];

  initial begin
    int lat;
    int seen;
    int guard;
    int last_cyc;
    int cyc;
    int n_res;
    int gaps_bad;
    int exp_q[$];
    logic negs_q[$];
    int vals[$];
    int idx;

    vecs[0] = '{0,   1'b0, 12'h000, 1'b0};
    vecs[1] = '{255, 1'b0, 12'h255, 1'b0};
    vecs[2] = '{128, 1'b1, 12'h128, 1'b1};
    vecs[3] = '{99,  1'b0, 12'h099, 1'b0};
    vecs[4] = '{1,   1'b1, 12'h001, 1'b1};
    vecs[5] = '{9,   1'b0, 12'h009, 1'b0};
    vecs[6] = '{10,  1'b0, 12'h010, 1'b0};
    vecs[7] = '{100, 1'b1, 12'h100, 1'b1};
    vecs[8] = '{199, 1'b0, 12'h199, 1'b0};
    vecs[9] = '{250, 1'b0, 12'h250, 1'b0};

    // Reset state, with a pending request that must not be taken in reset.
    in_valid = 1'b1;
    in_value = 8'd77;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_bcd", out_bcd, 0);
    check("rst_out_neg", out_neg, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready, 1);

    // Table-driven vectors including latency and state flags.
    for (int i = 0; i < 10; i++) begin
      in_value = IN_W'(vecs[i].value);
      in_neg   = vecs[i].neg;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check($sformatf("v%0d_busy", i), busy, 1);
      check($sformatf("v%0d_in_ready", i), in_ready, 0);
      lat = 0;
      for (int k = 1; k <= 30; k++) begin
        if (out_valid) break;
        @(posedge clk); #1;
        lat = k;
      end
      check($sformatf("v%0d_latency", i), lat, IN_W);
      check($sformatf("v%0d_bcd", i), out_bcd, vecs[i].exp_bcd);
      check($sformatf("v%0d_neg", i), out_neg, vecs[i].exp_neg);
      handshake();
      check($sformatf("v%0d_released", i), out_valid, 0);
    end

    // Output held while consumer stalls; input pulses ignored in DONE.
    accept_and_wait(99, 1'b0, lat);
    check("hold_latency", lat, IN_W);
    for (int c = 0; c < 5; c++) begin
      in_value = 8'd222;
      in_neg   = 1'b1;
      in_valid = (c % 2 == 0);
      @(posedge clk); #1;
      check($sformatf("hold%0d_valid", c), out_valid, 1);
      check($sformatf("hold%0d_bcd", c), out_bcd, 12'h099);
      check($sformatf("hold%0d_neg", c), out_neg, 0);
      check($sformatf("hold%0d_in_ready", c), in_ready, 0);
    end
    // Simultaneous out_ready and in_valid: only the output is consumed.
    in_value  = 8'd55;
    in_neg    = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("simul_busy", busy, 0);
    check("simul_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("simul_accept_busy", busy, 1);
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      if (out_valid) break;
      @(posedge clk); #1;
      lat = k;
    end
    check("simul_bcd", out_bcd, 12'h055);
    handshake();

    // Reset mid-conversion discards the result.
    in_value = 8'd200;
    in_neg   = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_bcd", out_bcd, 0);
    check("midrst_out_neg", out_neg, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen++;
    end
    check("midrst_no_result", seen, 0);
    accept_and_wait(37, 1'b0, lat);
    check("after_rst_latency", lat, IN_W);
    check("after_rst_bcd", out_bcd, 12'h037);
    handshake();

    // Streaming with both handshakes held high: 0..255 then random values.
    for (int v = 0; v < 256; v++) vals.push_back(v);
    for (int v = 0; v < 40; v++) vals.push_back(int'($urandom_range(0, 255)));
    idx = 0;
    n_res = 0;
    gaps_bad = 0;
    last_cyc = -1;
    cyc = 0;
    guard = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_value = IN_W'(vals[0]);
    in_neg = 1'($urandom);
    while (n_res < vals.size() && guard < 5000) begin
      @(negedge clk);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("stream_unexpected", 1, 0);
        end else begin
          if (out_bcd != BCD_W'(exp_q[0]) || out_neg != negs_q[0]) begin
            check($sformatf("stream%0d_bcd", n_res), {out_neg, out_bcd},
                  {negs_q[0], BCD_W'(exp_q[0])});
          end else begin
            checks++;
          end
          void'(exp_q.pop_front());
          void'(negs_q.pop_front());
        end
        if (last_cyc >= 0 && cyc - last_cyc != IN_W + 2) gaps_bad++;
        last_cyc = cyc;
        n_res++;
      end
      if (in_ready && in_valid) begin
        exp_q.push_back(int'(ref_bcd(vals[idx])));
        negs_q.push_back(in_neg);
        idx++;
      end
      @(posedge clk); #1;
      cyc++;
      guard++;
      if (idx < vals.size()) begin
        in_value = IN_W'(vals[idx]);
        in_neg = 1'($urandom);
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("stream_count", n_res, vals.size());
    check("stream_throughput_gaps", gaps_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
